// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register slice.
package id_ex_pipe_reg_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned REG_ZERO = 0;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'h9;

  // Control payload carried from ID into EX
  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic [ALU_OP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  // A bubble carries no side effects
  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module load_use_detect
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 6
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  hazard_c
);

  // A load into the zero register never produces a usable value, so it never stalls
  always_comb begin
    hazard_c = ex_valid && ex_mem_read && (ex_rd != REG_ADDR_W'(REG_ZERO)) && id_valid &&
               ((ex_rd == id_rs) || (ex_rd == id_rt));
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with bubble insertion, branch flush and external freeze.
// Build option: define LOAD_USE_DETECT_EN to enable load-use stall detection and
// the hazard bubble counter; otherwise load-use ordering is left to software.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_Rs,
  input  logic [REG_ADDR_W-1:0] i_id_Rt,
  input  logic [REG_ADDR_W-1:0] i_id_Rd,
  input  logic [DATA_W-1:0]     i_id_rs_data,
  input  logic [DATA_W-1:0]     i_id_rt_data,
  input  logic [DATA_W-1:0]     i_id_imm,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic                  i_id_mem_write,
  input  logic                  i_id_mem_to_reg,
  input  logic [ALU_OP_W-1:0]   i_id_alu_op,
  input  logic                  i_flush,
  input  logic                  i_ext_stall,
  output logic                  o_ID_EX_valid,
  output logic [REG_ADDR_W-1:0] o_ID_EX_Rs,
  output logic [REG_ADDR_W-1:0] o_ID_EX_Rt,
  output logic [REG_ADDR_W-1:0] o_ID_EX_Rd,
  output logic [DATA_W-1:0]     o_ID_EX_rs_data,
  output logic [DATA_W-1:0]     o_ID_EX_rt_data,
  output logic [DATA_W-1:0]     o_ID_EX_imm,
  output logic                  o_ID_EX_reg_write,
  output logic                  o_ID_EX_mem_read,
  output logic                  o_ID_EX_mem_write,
  output logic                  o_ID_EX_mem_to_reg,
  output logic [ALU_OP_W-1:0]   o_ID_EX_alu_op,
  output logic                  o_stall_if_id,
  output logic [CNT_W-1:0]      o_hazard_cnt
);

  id_ex_ctrl_t           ctrl_q, ctrl_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  hazard_c;

`ifdef LOAD_USE_DETECT_EN
  logic                  hz_load_c;
  logic [CNT_W-1:0]      hazard_cnt_q;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .ex_valid    (ctrl_q.valid),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (i_id_valid),
    .id_rs       (i_id_Rs),
    .id_rt       (i_id_Rt),
    .hazard_c    (hazard_c)
  );

  // A hazard bubble is loaded only when neither a freeze nor a flush outranks it
  assign hz_load_c = hazard_c && !i_ext_stall && !i_flush && !flush_pend_q;

  // Saturating count of inserted load-use bubbles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hazard_cnt_q <= '0;
    end else if (hz_load_c && (hazard_cnt_q != '1)) begin
      hazard_cnt_q <= hazard_cnt_q + CNT_W'(1);
    end
  end

  assign o_hazard_cnt = hazard_cnt_q;
`else
  assign hazard_c     = 1'b0;
  assign o_hazard_cnt = CNT_W'(0);
`endif

  // Flush discards the decode instruction, so it overrides the load-use stall
  assign o_stall_if_id = (hazard_c && !i_flush) || i_ext_stall;

  // Next-state selection: freeze, flush bubble, hazard bubble, or capture
  always_comb begin
    ctrl_d       = ctrl_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    flush_pend_d = flush_pend_q;
    if (i_ext_stall) begin
      if (i_flush) begin
        flush_pend_d = 1'b1;
      end
    end else if (i_flush || flush_pend_q || hazard_c) begin
      ctrl_d       = CTRL_BUBBLE;
      rs_d         = REG_ADDR_W'(REG_ZERO);
      rt_d         = REG_ADDR_W'(REG_ZERO);
      rd_d         = REG_ADDR_W'(REG_ZERO);
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      flush_pend_d = 1'b0;
    end else begin
      ctrl_d = CTRL_BUBBLE;
      if (i_id_valid) begin
        ctrl_d.valid      = 1'b1;
        ctrl_d.reg_write  = i_id_reg_write;
        ctrl_d.mem_read   = i_id_mem_read;
        ctrl_d.mem_write  = i_id_mem_write;
        ctrl_d.mem_to_reg = i_id_mem_to_reg;
        ctrl_d.alu_op     = i_id_alu_op;
      end
      rs_d      = i_id_Rs;
      rt_d      = i_id_Rt;
      rd_d      = i_id_Rd;
      rs_data_d = i_id_rs_data;
      rt_data_d = i_id_rt_data;
      imm_d     = i_id_imm;
    end
  end

  // Pipeline register state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q       <= CTRL_BUBBLE;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign o_ID_EX_valid      = ctrl_q.valid;
  assign o_ID_EX_reg_write  = ctrl_q.reg_write;
  assign o_ID_EX_mem_read   = ctrl_q.mem_read;
  assign o_ID_EX_mem_write  = ctrl_q.mem_write;
  assign o_ID_EX_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_ID_EX_alu_op     = ctrl_q.alu_op;
  assign o_ID_EX_Rs         = rs_q;
  assign o_ID_EX_Rt         = rt_q;
  assign o_ID_EX_Rd         = rd_q;
  assign o_ID_EX_rs_data    = rs_data_q;
  assign o_ID_EX_rt_data    = rt_data_q;
  assign o_ID_EX_imm        = imm_q;

endmodule
